// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer library: direction encoding and
// terminal-value computation, used by counters and timer blocks alike.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Terminal value of a modulo-N count for the given direction:
  // the highest legal value going up, zero going down.
  function automatic longint unsigned term_val(input longint unsigned modulus,
                                               input logic dir);
    return (dir == CNT_UP) ? (modulus - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/sync_updown_mod_counter.sv
// Synchronous modulo-N up/down counter with parallel load, cascadable
// terminal count, registered wrap pulse and optional one-shot stop.
module sync_updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = (64'd1 << WIDTH),
  parameter bit               ONESHOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  // Reject illegal configurations at elaboration rather than in silicon.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_updown_mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("sync_updown_mod_counter: MODULUS must be 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_val(MODULUS, CNT_UP));
  localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(term_val(MODULUS, CNT_DOWN));

  logic             at_term;
  logic [WIDTH-1:0] load_clamped;
  logic             done_q;

  // Terminal is judged against the direction presented this cycle, so a
  // direction flip takes effect at the very next edge.
  assign at_term      = (count == ((up_dn == CNT_UP) ? TERM_UP : TERM_DN));
  assign load_clamped = (load_val > TERM_UP) ? TERM_UP : load_val;

  // tc feeds the next stage's en; it must stay independent of wrap/done.
  assign tc   = en & at_term;
  assign done = ONESHOT ? done_q : 1'b0;

  // Count state: load beats enable; a stopped one-shot ignores en until reloaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wrap   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count  <= load_clamped;
        done_q <= 1'b0;
      end else if (en && !done_q) begin
        if (!at_term) begin
          count <= (up_dn == CNT_UP) ? count + 1'b1 : count - 1'b1;
        end else if (!ONESHOT) begin
          count <= (up_dn == CNT_UP) ? TERM_DN : TERM_UP;
          wrap  <= 1'b1;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sync_updown_mod_counter.md
# sync_updown_mod_counter

Parametrised synchronous modulo-N up/down counter. It is the general-purpose successor to the fixed 4-bit down counter, with:
- configurable width and modulus;
- run-time direction, count enable and synchronous parallel load;
- a cascade-friendly terminal-count output;
- an optional one-shot mode.

It sits in the lab's counter/timer library as the building block for dividers, timers and cascaded multi-digit counters.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (1..32)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal 2..2**WIDTH
- ONESHOT, 0, 0 = free-running wrap; 1 = stop at terminal count until reloaded

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-low reset (assert asynchronously, release synchronously upstream)
- en  input  1  count enable
- up_dn  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: en & at-terminal-for-current-direction
- wrap  output  1  registered one-cycle pulse, asserted the cycle after count wraps
- done  output  1  ONESHOT only: high while stopped at terminal; tied 0 when ONESHOT=0

## Operation
- Terminal value: MODULUS-1 when up_dn=1, 0 when up_dn=0.
- Per rising edge, in priority order:
  - load=1: count <= min(load_val, MODULUS-1); done <= 0; wrap <= 0. en is ignored.
  - en=1 and not at terminal: count increments (up) or decrements (down) by 1.
  - en=1 and at terminal, ONESHOT=0: count <= 0 (up) or MODULUS-1 (down); wrap <= 1.
  - en=1 and at terminal, ONESHOT=1: count holds; done <= 1; wrap <= 0. Counting does not resume until load.
  - en=0: count, done hold; wrap <= 0.
- wrap is 0 in every cycle not listed above.
- up_dn may change in any cycle; the new direction applies at the next edge. The terminal is re-evaluated against the new direction.
- Arithmetic: unsigned, modulo MODULUS. No intermediate value outside 0..MODULUS-1 is ever registered.
- ONESHOT=1 with done=1: a direction change that moves the count off-terminal does not restart counting. Only load clears done.
- Cascading: the tc of stage k drives en of stage k+1; all stages share clk and rst.

## Timing
- Reset (rst=0, asynchronous): count=0, wrap=0, done=0 immediately, regardless of clk. Takes effect mid-operation without waiting for an edge.
- First count change is at the first rising edge with rst=1 and en=1.
- load-to-count latency: 1 cycle.
- count-to-tc: combinational, same cycle. tc must never depend on wrap or done.
- wrap is aligned with the first cycle in which the wrapped value is visible on count.
- Down wrap with WIDTH=4 and MODULUS=16 matches the legacy sequence: 0 -> 15 -> 14 ...

## Structure
- Shared package counter_pkg:
  - direction constants CNT_UP=1'b1 and CNT_DOWN=1'b0;
  - a constant function for terminal-value computation, reused by the timer blocks.
- Single module. No sub-module is warranted.
- Elaboration-time check: fail the build if MODULUS < 2 or MODULUS > 2**WIDTH.

## Test plan
- Reset: hold rst=0 for 20 ns with clk running -> count=0, wrap=0, done=0. Release with en=1, up_dn=0 -> count sequence 15, 14, 13 ... (WIDTH=4, MODULUS=16).
- Modulo up: WIDTH=4, MODULUS=10, up_dn=1, en=1 from 0 -> 0..9, then 0. wrap=1 only in the cycle count returns to 0. tc=1 only while count=9.
- Load priority and clamp: load=1, en=1, load_val=12 with MODULUS=10 -> count=9 next cycle, no increment that cycle. load_val=3 -> count=3.
- Direction change: count=5 counting up; flip up_dn=0 -> next edge count=4. At count=0, down with en=1 -> tc=1, next count=9.
- One-shot: ONESHOT=1, MODULUS=16, load 13, count up -> 14, 15 then holds at 15, done=1, wrap never asserts. Load 2 -> done=0 and counting resumes.
- Async reset mid-count: assert rst=0 between clock edges at count=7 -> count=0 within the same cycle. Counting resumes from the post-reset value.
